oled_text_sequencer: RTL and testbench
======================================

OLED_TEXT_SEQUENCER -- requirements
Module: oled_text_sequencer

Interface
REQ-001 Parameter MAX_CHARS, default 16: character buffer depth, in characters per frame.
REQ-002 Parameter START_BYTE, default 8'h00: UART byte that opens a text frame.
REQ-003 Parameter END_BYTE, default 8'hFF: UART byte that closes a text frame.
REQ-004 CLOCK_50  in  1  single system clock; all logic on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rx_byte  in  8  received UART byte; valid only while rx_dval=1.
REQ-007 rx_dval  in  1  one-cycle strobe, one per received byte.
REQ-008 wr_req  out  1  write request to the OLED byte writer.
REQ-009 wr_dc  out  1  0 = command byte, 1 = character code; qualified by wr_req.
REQ-010 wr_byte  out  8  byte to write; qualified by wr_req.
REQ-011 wr_ack  in  1  one-cycle strobe from the writer; the current byte is accepted.
REQ-012 busy  out  1  high from frame close until the last byte is acknowledged.
REQ-013 frame_done  out  1  one-cycle pulse after the last byte of a frame is acknowledged.
REQ-014 overflow  out  1  sticky; set when a frame's characters are dropped; cleared at the next START_BYTE.
REQ-015 rx_drop  out  1  one-cycle pulse when an rx byte is discarded while busy=1.
REQ-016 page  out  3  display page used by the current or most recent frame.

Function
REQ-017 State machine: IDLE, COLLECT, CMD, CHAR, DONE.
REQ-018 IDLE: rx_dval with rx_byte==START_BYTE -> COLLECT, count=0, overflow=0. All other bytes are ignored.
REQ-019 COLLECT, non-delimiter byte: store at buf[count] and increment count. When count==MAX_CHARS, drop the byte and set overflow=1; count stays at MAX_CHARS.
REQ-020 COLLECT, START_BYTE: restart the frame with count=0 and overflow=0. The frame that was open is discarded and causes no writes.
REQ-021 COLLECT, END_BYTE with count==0: return to IDLE. No writes occur, busy stays 0, and frame_done does not pulse.
REQ-022 COLLECT, END_BYTE with count>0: next cycle busy=1 and state=CMD.
REQ-023 CMD issues 3 command bytes (wr_dc=0), in this order:
- 8'hB0|page
- 8'h00 (column low nibble)
- 8'h10 (column high nibble)
REQ-024 CHAR issues buf[0] .. buf[count-1] with wr_dc=1, in index order.
REQ-025 Handshake:
- wr_req rises the cycle after the state/index update.
- wr_req, wr_dc and wr_byte hold stable until the cycle wr_ack=1.
- wr_req is low the cycle after wr_ack.
- The next request is asserted the cycle after that, so there is at least 1 idle cycle between requests.
REQ-026 wr_ack while wr_req=0 is ignored.
REQ-027 After the last CHAR byte is acknowledged -> DONE for 1 cycle: frame_done=1, busy=0 the next cycle, page=page+1 (7 wraps to 0), then IDLE.
REQ-028 Any rx_dval while in CMD, CHAR or DONE pulses rx_drop the same cycle and changes nothing else.
REQ-029 rx_dval and wr_ack in the same cycle are both processed independently.
REQ-030 Maximum writes per frame: 3+MAX_CHARS. count width is clog2(MAX_CHARS+1).

Reset
REQ-031 reset=1 at a clock edge forces the following:
- state=IDLE, count=0, page=0
- wr_req=0, wr_dc=0, wr_byte=0
- busy=0, frame_done=0, overflow=0, rx_drop=0
REQ-032 Reset mid-transfer drops wr_req on the next edge. The buffer contents are not cleared and need not be.
REQ-033 After reset release, a wr_ack left over from the aborted transfer is ignored by REQ-026.

Verification
REQ-034 rx 00,'E'(45),'N'(4E),'G'(47),FF; writer acks 3 cycles after each req -> writes 0/B0, 0/00, 0/10, 1/45, 1/4E, 1/47; one frame_done; page becomes 1.
REQ-035 Overflow: 00, then 20 bytes 0x41..0x54, then FF -> writes 3 commands plus 0x41..0x50 (16 chars); overflow=1 until the next 00.
REQ-036 Empty frame and restart:
- 00,FF -> no wr_req and no frame_done.
- 00,'A',00,'B',FF -> single char 0x42 written.
REQ-037 Byte 'X' received during CHAR -> rx_drop pulses once; output sequence unchanged.
REQ-038 8 consecutive frames of 1 char each -> command page bytes B0..B7; the 9th frame uses B0.
REQ-039 reset asserted while wr_req=1 in CHAR -> wr_req=0 and busy=0 next cycle. A new frame 00,'Z',FF then starts with B0.

Source files
------------

// File: rtl/oled_text_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : oled_text_sequencer_if
// Brief    : UART receive / OLED byte-writer bus bundle for oled_text_sequencer.
// Revision : 1.0
// ============================================================================
interface oled_text_sequencer_if;
    logic [7:0] rx_byte;
    logic       rx_dval;
    logic       wr_req;
    logic       wr_dc;
    logic [7:0] wr_byte;
    logic       wr_ack;
    logic       busy;
    logic       frame_done;
    logic       overflow;
    logic       rx_drop;
    logic [2:0] page;

    modport slave (
        input  rx_byte, rx_dval, wr_ack,
        output wr_req, wr_dc, wr_byte, busy, frame_done, overflow, rx_drop, page
    );

    modport master (
        output rx_byte, rx_dval, wr_ack,
        input  wr_req, wr_dc, wr_byte, busy, frame_done, overflow, rx_drop, page
    );
endinterface
`default_nettype wire

// File: rtl/oled_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : oled_text_sequencer
// Brief    : Collects a delimited UART text frame, then writes page/column
//            commands and the characters to an OLED byte writer.
// Revision : 1.0
// ============================================================================
module oled_text_sequencer #(
    parameter int         MAX_CHARS  = 16,
    parameter logic [7:0] START_BYTE = 8'h00,
    parameter logic [7:0] END_BYTE   = 8'hFF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    oled_text_sequencer_if.slave  bus
);

    localparam int CW = $clog2(MAX_CHARS + 1);
    localparam int IW = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
    localparam logic [CW-1:0] c_MAX_CHARS = CW'(MAX_CHARS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_CMD     = 3'd2,
        S_CHAR    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_idx;
    logic [1:0]    r_cmd_idx;
    logic [7:0]    r_buf [MAX_CHARS];
    logic          r_wr_req;
    logic          r_wr_dc;
    logic [7:0]    r_wr_byte;
    logic          r_busy;
    logic          r_frame_done;
    logic          r_overflow;
    logic [2:0]    r_page;

    logic          w_is_start;
    logic          w_is_end;
    logic          w_store;
    logic          w_last_char;
    logic [7:0]    w_cmd_byte;
    logic [7:0]    w_char;
    logic          w_rx_drop;

    assign w_is_start  = bus.rx_dval && (bus.rx_byte == START_BYTE);
    assign w_is_end    = bus.rx_dval && (bus.rx_byte == END_BYTE);
    assign w_store     = (r_state == S_COLLECT) && bus.rx_dval && !w_is_start
                         && !w_is_end && (r_count != c_MAX_CHARS);
    assign w_last_char = ((r_idx + CW'(1)) == r_count);
    assign w_char      = r_buf[r_idx[IW-1:0]];
    assign w_rx_drop   = bus.rx_dval && !reset &&
                         ((r_state == S_CMD) || (r_state == S_CHAR) || (r_state == S_DONE));

    always_comb begin
        w_cmd_byte = 8'h10;
        case (r_cmd_idx)
            2'd0:    w_cmd_byte = {5'b10110, r_page};
            2'd1:    w_cmd_byte = 8'h00;
            default: w_cmd_byte = 8'h10;
        endcase
    end

    // Character storage is never reset; only r_count decides what is valid.
    always_ff @(posedge CLOCK_50) begin
        if (w_store) begin
            r_buf[r_count[IW-1:0]] <= bus.rx_byte;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_cmd_idx    <= 2'd0;
            r_wr_req     <= 1'b0;
            r_wr_dc      <= 1'b0;
            r_wr_byte    <= 8'h00;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_page       <= 3'd0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_is_start) begin
                        r_state    <= S_COLLECT;
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_is_start) begin
                        r_count    <= '0;
                        r_overflow <= 1'b0;
                    end else if (w_is_end) begin
                        if (r_count == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_CMD;
                            r_busy    <= 1'b1;
                            r_cmd_idx <= 2'd0;
                        end
                    end else if (bus.rx_dval) begin
                        if (r_count == c_MAX_CHARS) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_count <= r_count + CW'(1);
                        end
                    end
                end
                // A low wr_req here is always the idle cycle after an update,
                // so raising it now gives the required gap between requests.
                S_CMD: begin
                    if (!r_wr_req) begin
                        r_wr_req  <= 1'b1;
                        r_wr_dc   <= 1'b0;
                        r_wr_byte <= w_cmd_byte;
                    end else if (bus.wr_ack) begin
                        r_wr_req <= 1'b0;
                        if (r_cmd_idx == 2'd2) begin
                            r_state <= S_CHAR;
                            r_idx   <= '0;
                        end else begin
                            r_cmd_idx <= r_cmd_idx + 2'd1;
                        end
                    end
                end
                S_CHAR: begin
                    if (!r_wr_req) begin
                        r_wr_req  <= 1'b1;
                        r_wr_dc   <= 1'b1;
                        r_wr_byte <= w_char;
                    end else if (bus.wr_ack) begin
                        r_wr_req <= 1'b0;
                        if (w_last_char) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_idx <= r_idx + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_page  <= r_page + 3'd1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_req     = r_wr_req;
    assign bus.wr_dc      = r_wr_dc;
    assign bus.wr_byte    = r_wr_byte;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_frame_done;
    assign bus.overflow   = r_overflow;
    assign bus.rx_drop    = w_rx_drop;
    assign bus.page       = r_page;

endmodule
`default_nettype wire

// File: tb/tb_oled_text_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_oled_text_sequencer
// Brief    : Directed self-checking bench for oled_text_sequencer.
// Revision : 1.0
// ============================================================================
module tb_oled_text_sequencer;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    int   n_fdone;
    int   n_drop;
    int   n_rise;
    int   n_busy;
    logic r_prev_req;
    logic [8:0] got_q [$];
    logic [8:0] exp_q [$];

    oled_text_sequencer_if ifc ();

    oled_text_sequencer #(
        .MAX_CHARS  (16),
        .START_BYTE (8'h00),
        .END_BYTE   (8'hFF)
    ) u_dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ifc.frame_done === 1'b1) n_fdone++;
        if (ifc.rx_drop === 1'b1)    n_drop++;
        if (ifc.busy === 1'b1)       n_busy++;
        if (ifc.wr_req === 1'b1 && r_prev_req !== 1'b1) n_rise++;
        r_prev_req = ifc.wr_req;
    end

    // Writer model: acknowledges each request about three cycles later.
    initial begin
        logic [8:0] cap;
        logic       stable;
        logic       live;
        ifc.wr_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ifc.wr_req === 1'b1) begin
                cap    = {ifc.wr_dc, ifc.wr_byte};
                stable = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    if (ifc.wr_req !== 1'b1 || {ifc.wr_dc, ifc.wr_byte} !== cap) stable = 1'b0;
                end
                live = (ifc.wr_req === 1'b1);
                @(posedge clk); #1;
                ifc.wr_ack = 1'b1;
                if (live) begin
                    got_q.push_back(cap);
                    chk("hold", {31'd0, stable}, 32'd1);
                end
                @(posedge clk); #1;
                ifc.wr_ack = 1'b0;
                @(negedge clk);
                if (live) chk("gap", {31'd0, ifc.wr_req}, 32'd0);
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk); #1;
        ifc.rx_byte = b;
        ifc.rx_dval = 1'b1;
        @(posedge clk); #1;
        ifc.rx_dval = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit saw = 0;
        bit ok  = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (ifc.busy === 1'b1) saw = 1;
            else if (saw) begin ok = 1; break; end
        end
        if (!ok) chk({tag, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic exp_frame(input logic [2:0] pg);
        exp_q.push_back({1'b0, 5'b10110, pg});
        exp_q.push_back(9'h000);
        exp_q.push_back(9'h010);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_n"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int fd0, dr0, ri0, bz0;
        n_chk = 0; n_err = 0; n_fdone = 0; n_drop = 0; n_rise = 0; n_busy = 0;
        r_prev_req = 1'b0;
        ifc.rx_byte = 8'h00;
        ifc.rx_dval = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_wr_req", {31'd0, ifc.wr_req}, 32'd0);
        chk("rst_wr_dc", {31'd0, ifc.wr_dc}, 32'd0);
        chk("rst_wr_byte", {24'd0, ifc.wr_byte}, 32'd0);
        chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("rst_fdone", {31'd0, ifc.frame_done}, 32'd0);
        chk("rst_ovf", {31'd0, ifc.overflow}, 32'd0);
        chk("rst_drop", {31'd0, ifc.rx_drop}, 32'd0);
        chk("rst_page", {29'd0, ifc.page}, 32'd0);

        // Basic three-character frame
        fd0 = n_fdone;
        send(8'h00); send(8'h45); send(8'h4E); send(8'h47); send(8'hFF);
        wait_idle("eng");
        exp_frame(3'd0);
        exp_q.push_back(9'h145); exp_q.push_back(9'h14E); exp_q.push_back(9'h147);
        cmp_writes("eng");
        chk("eng_fdone", n_fdone - fd0, 32'd1);
        chk("eng_page", {29'd0, ifc.page}, 32'd1);

        // Overflow: 20 characters, only the first 16 are kept
        send(8'h00);
        for (int i = 0; i < 16; i++) send(8'h41 + 8'(i));
        chk("ovf_at16", {31'd0, ifc.overflow}, 32'd0);
        send(8'h51);
        chk("ovf_at17", {31'd0, ifc.overflow}, 32'd1);
        for (int i = 17; i < 20; i++) send(8'h41 + 8'(i));
        send(8'hFF);
        wait_idle("ovf");
        exp_frame(3'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, 8'h41 + 8'(i)});
        cmp_writes("ovf");
        chk("ovf_sticky", {31'd0, ifc.overflow}, 32'd1);
        chk("ovf_page", {29'd0, ifc.page}, 32'd2);

        // Empty frame
        fd0 = n_fdone; ri0 = n_rise; bz0 = n_busy;
        send(8'h00);
        chk("ovf_clear", {31'd0, ifc.overflow}, 32'd0);
        send(8'hFF);
        repeat (10) @(negedge clk);
        chk("empty_req", n_rise - ri0, 32'd0);
        chk("empty_fdone", n_fdone - fd0, 32'd0);
        chk("empty_busy", n_busy - bz0, 32'd0);

        // Restart discards the first open frame
        send(8'h00); send(8'h41); send(8'h00); send(8'h42); send(8'hFF);
        wait_idle("rst");
        exp_frame(3'd2);
        exp_q.push_back(9'h142);
        cmp_writes("restart");

        // Byte received during CHAR is dropped
        dr0 = n_drop;
        send(8'h00); send(8'h41); send(8'h42); send(8'h43); send(8'hFF);
        for (int n = 0; n < 300 && got_q.size() < 4; n++) @(negedge clk);
        chk("drop_inchar", {31'd0, (got_q.size() >= 4)}, 32'd1);
        send(8'h58);
        wait_idle("drop");
        exp_frame(3'd3);
        exp_q.push_back(9'h141); exp_q.push_back(9'h142); exp_q.push_back(9'h143);
        cmp_writes("drop");
        chk("drop_cnt", n_drop - dr0, 32'd1);
        chk("drop_page", {29'd0, ifc.page}, 32'd4);

        // Reset while a character request is pending
        send(8'h00); send(8'h50); send(8'h51); send(8'h52); send(8'hFF);
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (got_q.size() >= 4 && ifc.wr_req === 1'b1) break;
        end
        chk("mid_req", {31'd0, ifc.wr_req}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_req", {31'd0, ifc.wr_req}, 32'd0);
        chk("mid_rst_busy", {31'd0, ifc.busy}, 32'd0);
        chk("mid_rst_page", {29'd0, ifc.page}, 32'd0);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        got_q.delete();
        exp_q.delete();
        send(8'h00); send(8'h5A); send(8'hFF);
        wait_idle("z");
        exp_frame(3'd0);
        exp_q.push_back(9'h15A);
        cmp_writes("after_rst");

        // Nine single-character frames walk and wrap the page
        do_reset();
        for (int f = 0; f < 9; f++) begin
            send(8'h00); send(8'h30 + 8'(f)); send(8'hFF);
            wait_idle("pg");
            exp_frame(3'(f % 8));
            exp_q.push_back({1'b1, 8'h30 + 8'(f)});
            cmp_writes($sformatf("pg%0d", f));
        end
        chk("pg_final", {29'd0, ifc.page}, 32'd1);
        chk("drop_total", n_drop, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
